cmp_sweep_checker: RTL and testbench
====================================

# cmp_sweep_checker

Self-contained stimulus-and-check engine for the 4-bit dual comparator (`ans1` = signed a<b, `ans2` = unsigned a<b). On a start pulse it drives all 256 (a,b) operand pairs, one per cycle, onto the comparator inputs. It re-aligns the returned `ans1`/`ans2` with an internally computed expected value and reports the mismatch count and the first failing pair. It is the driving and checking end of the comparator interface and replaces hand-written stimulus in on-board self-test.

## Interface
- `LAT`, default 1: comparator response latency in cycles, legal range 0..4. 0 means the response is combinational and is sampled in the same cycle the pair is presented.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request, sampled at the rising edge.
- `a` out 4: operand A to the comparator.
- `b` out 4: operand B to the comparator.
- `ans1` in 1: comparator result, signed(a) < signed(b).
- `ans2` in 1: comparator result, unsigned a < b.
- `busy` out 1: sweep or drain in progress.
- `done` out 1: sweep finished. Level signal, held until the next accepted start or reset.
- `err_cnt` out 9: number of pairs with any mismatch, range 0..256.
- `first_err_vld` out 1: at least one mismatch recorded.
- `first_err_a` out 4: A operand of the first mismatching pair.
- `first_err_b` out 4: B operand of the first mismatching pair.

## Operation
- FSM states:
  - IDLE: entered from reset. Goes to SWEEP on `start`=1.
  - SWEEP: 256 cycles. Goes to DRAIN when the index reaches 255 and LAT>0, or directly to DONE when LAT=0.
  - DRAIN: LAT cycles. Goes to DONE.
  - DONE: goes to SWEEP on `start`=1.
- Sweep index:
  - 8-bit index `idx` runs 0..255 with `a`=idx[7:4] and `b`=idx[3:0], so the order is (0,0),(0,1)…(0,15),(1,0)…(15,15).
  - There is no wrap: the index stops at 255.
- Expected value per pair:
  - exp1 = $signed(a) < $signed(b).
  - exp2 = a < b, unsigned.
- Alignment pipeline:
  - {valid, a, b, exp1, exp2} is delayed LAT stages.
  - With LAT=0 there is no delay.
- Check rules:
  - When the delayed valid is set, a mismatch is (ans1≠exp1) OR (ans2≠exp2).
  - Each mismatch increments `err_cnt` by 1, counting at most 1 per pair.
  - On the first mismatch only, latch `first_err_a`/`first_err_b` and set `first_err_vld`.
- Output values by state:
  - `a`/`b` are 0 in IDLE, DRAIN and DONE.
  - `ans1`/`ans2` are ignored whenever the delayed valid is clear.
- Start handling:
  - Accepting `start` in IDLE or DONE clears `err_cnt`, `first_err_*` and `done`, and resets `idx` to 0.
  - `start` is ignored in SWEEP and DRAIN.
- Reset:
  - `reset`=0 at any time, including mid-sweep, immediately forces state IDLE, `idx`=0, pipeline valids 0, and every output 0.
  - After reset release, the next `start` begins a complete new sweep.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `err_cnt`=0, `first_err_vld`=0, `first_err_a`=0, `first_err_b`=0.
- Let edge E0 be the edge that samples `start`=1 in IDLE or DONE.
- `busy` goes to 1 after E0.
- Pair n (n=0..255) is driven in the cycle after edge E0+n.
- The response for pair n is sampled at edge E0+n+1+LAT.
- `err_cnt` reflects pair n after that edge.
- After edge E0+256+LAT: `busy`=0, `done`=1, and all counters are final.
- Total sweep is therefore 256+LAT cycles from E0 to `done`.
- `a`/`b` are registered outputs, with no combinational path from `start`.
- A `start` pulse sampled in the same cycle that `done` rises (end of DRAIN) is ignored. A `start` sampled in DONE is accepted.

## Test plan
- Correct behavioural comparator, LAT=1, one start pulse:
  - `done` rises 257 cycles after E0.
  - `err_cnt`=0 and `first_err_vld`=0.
  - During the sweep, pair (4,15) gives ans1=0 (4 < -1 is false) and ans2=1.
- `ans2` stuck at 0, LAT=1:
  - `err_cnt`=120.
  - `first_err_vld`=1, first error (a,b)=(0,1).
- `ans1` inverted, LAT=0, combinational model:
  - `err_cnt`=256.
  - First error (a,b)=(0,0).
  - `done` 256 cycles after E0.
- `start` pulsed again at pair 50 while busy:
  - It is ignored.
  - The sweep completes with a single 256-pair pass and `err_cnt` unchanged versus the clean run.
- `reset`=0 asserted asynchronously mid-cycle at pair 100:
  - All outputs go to 0 before the next edge.
  - After release and a new start, a full sweep completes with `err_cnt`=0.
- Back-to-back sweeps: `start` in DONE after a faulty run (err_cnt=120), with the fault removed:
  - `err_cnt` and `first_err_vld` clear at E0.
  - The final result is `err_cnt`=0.

Source files
------------

// File: rtl/cmp_sweep_checker.sv
// Exhaustive 4-bit dual-comparator stimulus and checker.
// Sweeps all 256 (a,b) pairs and tallies response mismatches.
module cmp_sweep_checker #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic       ans1,
  input  logic       ans2,
  output logic       busy,
  output logic       done,
  output logic [8:0] err_cnt,
  output logic       first_err_vld,
  output logic [3:0] first_err_a,
  output logic [3:0] first_err_b
);

  localparam int D = (LAT > 0) ? LAT : 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       e1;
    logic       e2;
  } tag_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] idx_q;
  logic [2:0] dcnt_q;
  logic       vld_q;
  logic       go;
  logic       idx_end;
  logic       dlast;
  tag_t       cur;
  tag_t       chk;
  tag_t       pipe_q [D];
  logic       mis;

  always_comb begin
    go      = start && (state_q == IDLE || state_q == DONE);
    idx_end = (idx_q == 8'hff);
    dlast   = (dcnt_q == 3'(LAT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: if (idx_end) state_d = (LAT == 0) ? DONE : DRAIN;
      DRAIN: if (dlast) state_d = DONE;
      DONE:  if (start) state_d = SWEEP;
      default: state_d = IDLE;
    endcase
  end

  // a/b mirror idx while a pair is live, and sit at 0 otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      vld_q  <= 1'b0;
      a      <= '0;
      b      <= '0;
      dcnt_q <= '0;
    end else if (go) begin
      idx_q  <= '0;
      vld_q  <= 1'b1;
      a      <= '0;
      b      <= '0;
      dcnt_q <= '0;
    end else if (state_q == SWEEP) begin
      if (idx_end) begin
        vld_q <= 1'b0;
        a     <= '0;
        b     <= '0;
      end else begin
        idx_q    <= idx_q + 8'd1;
        {a, b}   <= idx_q + 8'd1;
      end
    end else if (state_q == DRAIN) begin
      dcnt_q <= dcnt_q + 3'd1;
    end
  end

  always_comb begin
    cur.v  = vld_q;
    cur.a  = a;
    cur.b  = b;
    cur.e1 = $signed(a) < $signed(b);
    cur.e2 = a < b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= cur;
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    chk = (LAT == 0) ? cur : pipe_q[D-1];
    mis = chk.v && ((ans1 != chk.e1) || (ans2 != chk.e2));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
    end else if (go) begin
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
    end else if (mis) begin
      err_cnt <= err_cnt + 9'd1;
      if (!first_err_vld) begin
        first_err_vld <= 1'b1;
        first_err_a   <= chk.a;
        first_err_b   <= chk.b;
      end
    end
  end

  assign busy = (state_q == SWEEP) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Directed bench for cmp_sweep_checker: registered (LAT=1)
// and combinational (LAT=0) comparator models with faults.
module tb_cmp_sweep_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s1 = 1'b0;
  logic       s0 = 1'b0;
  logic       stuck = 1'b0;
  logic       inv = 1'b0;

  logic [3:0] a1, b1, fa1, fb1;
  logic [3:0] a0, b0, fa0, fb0;
  logic       busy1, done1, fev1;
  logic       busy0, done0, fev0;
  logic [8:0] err1, err0;
  logic       r1 = 1'b0;
  logic       r2 = 1'b0;
  logic       ans1_1, ans2_1, ans1_0, ans2_0;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic prev415 = 1'b0;
  logic seen415 = 1'b0;
  logic c1 = 1'b0;
  logic c2 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1 <= $signed(a1) < $signed(b1);
    r2 <= a1 < b1;
  end
  assign ans1_1 = r1;
  assign ans2_1 = stuck ? 1'b0 : r2;
  assign ans1_0 = inv ^ ($signed(a0) < $signed(b0));
  assign ans2_0 = a0 < b0;

  always @(negedge clk) begin
    if (prev415) begin
      seen415 = 1'b1;
      c1 = ans1_1;
      c2 = ans2_1;
    end
    prev415 = (a1 == 4'd4) && (b1 == 4'd15);
  end

  cmp_sweep_checker #(.LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(s1),
    .a(a1), .b(b1), .ans1(ans1_1), .ans2(ans2_1),
    .busy(busy1), .done(done1), .err_cnt(err1),
    .first_err_vld(fev1), .first_err_a(fa1), .first_err_b(fb1)
  );

  cmp_sweep_checker #(.LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(s0),
    .a(a0), .b(b0), .ans1(ans1_0), .ans2(ans2_0),
    .busy(busy0), .done(done0), .err_cnt(err0),
    .first_err_vld(fev0), .first_err_a(fa0), .first_err_b(fb0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sweep1(input int pulse_at, output int n);
    @(negedge clk);
    s1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s1 = 1'b0;
    chk("busy_e0", busy1, 1);
    chk("done_e0", done1, 0);
    chk("err_e0", err1, 0);
    chk("fev_e0", fev1, 0);
    chk("ab_e0", {a1, b1}, 0);
    n = 0;
    while (!done1 && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      s1 = (pulse_at >= 0) && ({a1, b1} == 8'(pulse_at));
    end
    s1 = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a", a1, 0);
    chk("rst_b", b1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    chk("rst_fev", fev1, 0);
    chk("rst_fab", {fa1, fb1}, 0);
    chk("rst_l0", {busy0, done0, err0, fev0, a0, b0}, 0);
    reset = 1'b1;

    // clean run, LAT=1
    sweep1(-1, cyc);
    chk("clean_cyc", cyc, 257);
    chk("clean_err", err1, 0);
    chk("clean_fev", fev1, 0);
    chk("clean_busy", busy1, 0);
    chk("clean_ab", {a1, b1}, 0);
    chk("seen_4_15", seen415, 1);
    chk("ans1_4_15", c1, 0);
    chk("ans2_4_15", c2, 1);

    // ans2 stuck at 0
    stuck = 1'b1;
    sweep1(-1, cyc);
    chk("stuck_cyc", cyc, 257);
    chk("stuck_err", err1, 120);
    chk("stuck_fev", fev1, 1);
    chk("stuck_fa", fa1, 0);
    chk("stuck_fb", fb1, 1);

    // back-to-back from DONE with fault removed
    stuck = 1'b0;
    sweep1(-1, cyc);
    chk("b2b_cyc", cyc, 257);
    chk("b2b_err", err1, 0);
    chk("b2b_fev", fev1, 0);

    // start while busy at pair 50
    sweep1(50, cyc);
    chk("rst50_cyc", cyc, 257);
    chk("pulse_err", err1, 0);
    repeat (3) @(negedge clk);
    chk("pulse_hold_done", done1, 1);
    chk("pulse_hold_busy", busy1, 0);

    // async reset at pair 100 during a faulty sweep
    stuck = 1'b1;
    @(negedge clk);
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    cyc = 0;
    while ({a1, b1} != 8'd100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_rst_err_nz", err1 != 0, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ab", {a1, b1}, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_err", err1, 0);
    chk("mid_rst_fev", fev1, 0);
    chk("mid_rst_fab", {fa1, fb1}, 0);
    @(negedge clk);
    reset = 1'b1;
    stuck = 1'b0;
    sweep1(-1, cyc);
    chk("post_rst_cyc", cyc, 257);
    chk("post_rst_err", err1, 0);

    // LAT=0 with ans1 inverted
    inv = 1'b1;
    @(negedge clk);
    s0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s0 = 1'b0;
    chk("l0_busy_e0", busy0, 1);
    cyc = 0;
    while (!done0 && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("l0_cyc", cyc, 256);
    chk("l0_err", err0, 256);
    chk("l0_fev", fev0, 1);
    chk("l0_fab", {fa0, fb0}, 0);
    chk("l0_ab", {a0, b0}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
